// File: rtl/matrix_subtractor_2x2_seq.sv
// 2x2 matrix subtractor: recovers B = C - A one element per cycle behind a
// valid/ready handshake, flagging elements whose true difference leaves AW bits.
module matrix_subtractor_2x2_seq #(
   parameter int AW = 3,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] a11,
   input  logic [AW-1:0] a12,
   input  logic [AW-1:0] a21,
   input  logic [AW-1:0] a22,
   input  logic [CW-1:0] c11,
   input  logic [CW-1:0] c12,
   input  logic [CW-1:0] c21,
   input  logic [CW-1:0] c22,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] b11,
   output logic [AW-1:0] b12,
   output logic [AW-1:0] b21,
   output logic [AW-1:0] b22,
   output logic [3:0]    err,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [3:0][AW-1:0]   a_q, a_d;
   logic [3:0][CW-1:0]   c_q, c_d;
   logic [3:0][AW-1:0]   b_q, b_d;
   logic [3:0]           err_q, err_d;
   logic [AW:0]          elem;
   logic                 accept;

   // Returns {range_error, wrapped_difference}. d always fits in CW+1 signed
   // bits, so any set bit from AW upward means negative or above 2^AW-1.
   function automatic logic [AW:0] sub_elem(input logic [AW-1:0] a,
                                            input logic [CW-1:0] c);
      logic signed [CW:0] d;
      d = $signed({1'b0, c}) - $signed({{(CW+1-AW){1'b0}}, a});
      return {(|d[CW:AW]), d[AW-1:0]};
   endfunction

   assign accept = in_valid && in_ready;
   assign elem   = sub_elem(a_q[idx_q], c_q[idx_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = CALC;
         CALC:    if (idx_q == 2'd3) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   always_comb begin
      a_d   = a_q;
      c_d   = c_q;
      b_d   = b_q;
      err_d = err_q;
      idx_d = idx_q;
      if (accept) begin
         a_d   = {a22, a21, a12, a11};
         c_d   = {c22, c21, c12, c11};
         b_d   = '0;
         err_d = '0;
         idx_d = 2'd0;
      end else if (state_q == CALC) begin
         b_d[idx_q]   = elem[AW-1:0];
         err_d[idx_q] = elem[AW];
         idx_d        = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= 2'd0;
         a_q   <= '0;
         c_q   <= '0;
         b_q   <= '0;
         err_q <= '0;
      end else begin
         idx_q <= idx_d;
         a_q   <= a_d;
         c_q   <= c_d;
         b_q   <= b_d;
         err_q <= err_d;
      end
   end

   assign b11 = b_q[0];
   assign b12 = b_q[1];
   assign b21 = b_q[2];
   assign b22 = b_q[3];
   assign err = err_q;

endmodule

// File: tb/tb_matrix_subtractor_2x2_seq.sv
// Scoreboard bench for matrix_subtractor_2x2_seq: directed matrices with
// hand-computed results plus a full a x c sweep at every element position.
module tb_matrix_subtractor_2x2_seq;
   localparam int AW = 3;
   localparam int CW = 4;

   typedef struct packed {
      logic [3:0][AW-1:0] b;
      logic [3:0]         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic in_ready, out_valid, busy;
   logic [AW-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
   logic [CW-1:0] c11, c12, c21, c22;
   logic [3:0] err;
   logic [3:0][AW-1:0] a_v = '0;
   logic [3:0][CW-1:0] c_v = '0;
   logic [3:0][AW-1:0] b_obs;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int nres = 0;
   exp_t sb[$];
   logic [3:0][AW-1:0] vec_a[$];
   logic [3:0][CW-1:0] vec_c[$];
   exp_t vec_e[$];

   assign {a22, a21, a12, a11} = a_v;
   assign {c22, c21, c12, c11} = c_v;
   assign b_obs = {b22, b21, b12, b11};

   matrix_subtractor_2x2_seq #(.AW(AW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .c11(c11), .c12(c12), .c21(c21), .c22(c22),
      .out_valid(out_valid), .out_ready(out_ready),
      .b11(b11), .b12(b12), .b21(b21), .b22(b22),
      .err(err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] b0, input logic [2:0] b1,
                               input logic [2:0] b2, input logic [2:0] b3,
                               input logic [3:0] e);
      exp_t r;
      r.b = {b3, b2, b1, b0};
      r.err = e;
      return r;
   endfunction

   // Independent reference: plain integer difference, modulo 8 and range test.
   function automatic exp_t model(input logic [3:0][AW-1:0] a, input logic [3:0][CW-1:0] c);
      exp_t r;
      for (int p = 0; p < 4; p++) begin
         int d;
         d = int'(c[p]) - int'(a[p]);
         r.b[p] = 3'(((d % 8) + 8) % 8);
         r.err[p] = (d < 0) || (d > 7);
      end
      return r;
   endfunction

   // Monitor: a handshake happens at the posedge after any negedge with valid&&ready.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 32'(b_obs), 32'hFFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk($sformatf("result_b_%0d", nres), 32'(b_obs), 32'(e.b));
               chk($sformatf("result_err_%0d", nres), 32'(err), 32'(e.err));
            end
            nres++;
         end
      end
   end

   task automatic send(input logic [3:0][AW-1:0] a, input logic [3:0][CW-1:0] c,
                       input bit push, input exp_t e);
      int n;
      a_v = a;
      c_v = c;
      in_valid = 1'b1;
      for (n = 0; n < 30; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (n == 30) chk("accept_timeout", 32'(n), 32'd0);
      else if (push) sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic stream(input string tag);
      int prev;
      int n;
      prev = 0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < vec_a.size(); k++) begin
         a_v = vec_a[k];
         c_v = vec_c[k];
         for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (in_ready) break;
         end
         if (n == 30) begin
            chk({tag, "_accept_timeout"}, 32'(n), 32'd0);
         end else begin
            sb.push_back(vec_e[k]);
            if (k > 0) chk($sformatf("%s_spacing_%0d", tag, k), 32'(cyc - prev), 32'd6);
            prev = cyc;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      vec_a.delete();
      vec_c.delete();
      vec_e.delete();
   endtask

   initial begin
      exp_t snap_e;
      logic [15:0] snap;
      int n;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_b", 32'(b_obs), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;

      // Idle out_ready does nothing
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Adder inverse with latency
      send({3'd0, 3'd7, 3'd5, 3'd3}, {4'd7, 4'd14, 4'd12, 4'd5}, 1'b1,
           mk(3'd2, 3'd7, 3'd7, 3'd7, 4'b0000));
      chk("lat_busy", 32'(busy), 32'd1);
      chk("lat_in_ready", 32'(in_ready), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("lat_out_valid_T%0d", k), 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
      end
      repeat (3) @(posedge clk);
      #1;

      // Range errors
      send({3'd6, 3'd1, 3'd0, 3'd5}, {4'd6, 4'd4, 4'd15, 4'd2}, 1'b1,
           mk(3'd5, 3'd7, 3'd3, 3'd0, 4'b0011));
      repeat (8) @(posedge clk);
      #1;

      // Reset mid-CALC after two elements: nothing must come out
      send({3'd0, 3'd0, 3'd1, 3'd1}, {4'd6, 4'd6, 4'd6, 4'd6}, 1'b0, '0);
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("midcalc_b_pre", 32'(b_obs), 32'(mk(3'd5, 3'd5, 3'd0, 3'd0, 4'b0).b));
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_b", 32'(b_obs), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_completion", 32'(out_valid), 32'd0);

      // Backpressure in DONE
      out_ready = 1'b0;
      snap_e = mk(3'd0, 3'd7, 3'd7, 3'd0, 4'b0001);
      send({3'd4, 3'd3, 3'd2, 3'd1}, {4'd4, 4'd10, 4'd9, 4'd9}, 1'b1, snap_e);
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      if (n == 20) chk("bp_valid_timeout", 32'(n), 32'd0);
      snap = {b_obs, err};
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 3) begin
            a_v = {3'd7, 3'd7, 3'd7, 3'd7};
            c_v = '0;
            in_valid = 1'b1;
         end
         if (k == 5) in_valid = 1'b0;
         chk($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
         chk($sformatf("bp_hold_%0d", k), 32'({b_obs, err}), 32'(snap));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_retain", 32'({b_obs, err}), 32'(snap));
      repeat (4) @(posedge clk);
      #1;
      chk("bp_pulse_ignored", 32'(busy), 32'd0);

      // Back-to-back, hand-computed
      vec_a.push_back({3'd0, 3'd7, 3'd5, 3'd3});
      vec_c.push_back({4'd7, 4'd14, 4'd12, 4'd5});
      vec_e.push_back(mk(3'd2, 3'd7, 3'd7, 3'd7, 4'b0000));
      vec_a.push_back({3'd6, 3'd1, 3'd0, 3'd5});
      vec_c.push_back({4'd6, 4'd4, 4'd15, 4'd2});
      vec_e.push_back(mk(3'd5, 3'd7, 3'd3, 3'd0, 4'b0011));
      vec_a.push_back({3'd1, 3'd0, 3'd7, 3'd7});
      vec_c.push_back({4'd0, 4'd0, 4'd15, 4'd7});
      vec_e.push_back(mk(3'd0, 3'd0, 3'd0, 3'd7, 4'b1010));
      stream("b2b");

      // Sweep: every (a,c) pair appears at every element position
      for (int k = 0; k < 128; k++) begin
         logic [3:0][AW-1:0] a;
         logic [3:0][CW-1:0] c;
         for (int p = 0; p < 4; p++) begin
            int combo;
            combo = (k + 32 * p) % 128;
            a[p] = 3'(combo / 16);
            c[p] = 4'(combo % 16);
         end
         vec_a.push_back(a);
         vec_c.push_back(c);
         vec_e.push_back(model(a, c));
      end
      stream("sweep");

      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) break;
      end
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end
endmodule
